alu_share_arb: RTL and testbench

- Arbitrates one combinational ALU between two requesters: requester 0 is the IEU execute stage, requester 1 is a multicycle sequencer.
- Grants at most one request per cycle using round-robin. Drives the operands and control fields onto the ALU and captures the ALU result into a per-requester response register.
- Responses use valid/ready handshakes, so either requester can apply backpressure without stalling the other.

---
 rtl/alu_share_arb.sv | 93 +++++++++
 tb/tb_alu_share_arb.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin share of one combinational ALU between two requesters
module alu_share_arb #(
  parameter int WIDTH = 64,
  parameter int CTRLW = 16,
  parameter int TAGW  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 ReqValid,
  output logic [1:0]                 ReqReady,
  input  logic [1:0][WIDTH-1:0]      ReqA,
  input  logic [1:0][WIDTH-1:0]      ReqB,
  input  logic [1:0][CTRLW-1:0]      ReqCtrl,
  input  logic [1:0][TAGW-1:0]       ReqTag,
  input  logic [1:0]                 Flush,
  output logic [1:0]                 RspValid,
  input  logic [1:0]                 RspReady,
  output logic [1:0][WIDTH-1:0]      RspResult,
  output logic [1:0][TAGW-1:0]       RspTag,
  output logic [WIDTH-1:0]           AluA,
  output logic [WIDTH-1:0]           AluB,
  output logic [CTRLW-1:0]           AluCtrl,
  input  logic [WIDTH-1:0]           AluResult
);

  logic                   prio_q, prio_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0][WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic [1:0][TAGW-1:0]   rsp_tag_q, rsp_tag_d;
  logic [1:0]             elig;
  logic [1:0]             grant;
  logic                   sel;

  // A slot being drained this cycle counts as free, so each requester can sustain 1 op/cycle.
  assign elig = ReqValid & ~Flush & (~rsp_valid_q | RspReady);

  always_comb begin
    grant = 2'b00;
    if (reset) begin
      if (elig == 2'b11) begin
        grant = prio_q ? 2'b10 : 2'b01;
      end else begin
        grant = elig;
      end
    end
  end

  assign ReqReady = grant;
  assign sel      = grant[1];
  assign AluA     = ReqA[sel];
  assign AluB     = ReqB[sel];
  assign AluCtrl  = ReqCtrl[sel];

  always_comb begin
    prio_d       = prio_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    if (grant != 2'b00) begin
      prio_d = grant[0];
    end
    for (int i = 0; i < 2; i++) begin
      if (Flush[i]) begin
        rsp_valid_d[i] = 1'b0;
      end else if (grant[i]) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = AluResult;
        rsp_tag_d[i]    = ReqTag[i];
      end else if (rsp_valid_q[i] && RspReady[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q       <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      prio_q       <= prio_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign RspValid  = rsp_valid_q;
  assign RspResult = rsp_result_q;
  assign RspTag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed vector bench for alu_share_arb
module tb_alu_share_arb;
  localparam int WIDTH = 64;
  localparam int CTRLW = 16;
  localparam int TAGW  = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             ReqValid, ReqReady, Flush, RspValid, RspReady;
  logic [1:0][WIDTH-1:0]  ReqA, ReqB, RspResult;
  logic [1:0][CTRLW-1:0]  ReqCtrl;
  logic [1:0][TAGW-1:0]   ReqTag, RspTag;
  logic [WIDTH-1:0]       AluA, AluB, AluResult;
  logic [CTRLW-1:0]       AluCtrl;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: SubArith (ctrl bit 14) selects subtract, otherwise add.
  assign AluResult = AluCtrl[14] ? (AluA - AluB) : (AluA + AluB);

  alu_share_arb #(.WIDTH(WIDTH), .CTRLW(CTRLW), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA(ReqA), .ReqB(ReqB), .ReqCtrl(ReqCtrl), .ReqTag(ReqTag),
    .Flush(Flush),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspResult(RspResult), .RspTag(RspTag),
    .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl), .AluResult(AluResult)
  );

  typedef struct packed {
    logic [1:0] valid, flush, rdy;
    logic [7:0] a0, b0; logic s0; logic [3:0] t0;
    logic [7:0] a1, b1; logic s1; logic [3:0] t1;
    logic [1:0] exp_ready, exp_rv;
    logic [7:0] exp_r0; logic [3:0] exp_t0;
    logic [7:0] exp_r1; logic [3:0] exp_t1;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] f, input logic [1:0] r,
                       input logic [7:0] a0, input logic [7:0] b0, input logic s0, input logic [3:0] t0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic s1, input logic [3:0] t1);
    ReqValid   = v;
    Flush      = f;
    RspReady   = r;
    ReqA[0]    = {56'd0, a0};
    ReqB[0]    = {56'd0, b0};
    ReqCtrl[0] = {1'b1, s0, 14'd0};
    ReqTag[0]  = t0;
    ReqA[1]    = {56'd0, a1};
    ReqB[1]    = {56'd0, b1};
    ReqCtrl[1] = {1'b1, s1, 14'd0};
    ReqTag[1]  = t1;
  endtask

  initial begin
    //           valid  flush  rdy    a0  b0 s0 t0   a1  b1 s1 t1   rdy    rv     r0  t0  r1  t1
    vecs[0]  = '{2'b00, 2'b00, 2'b11,  0,  0, 0, 0,   0,  0, 0, 0,  2'b00, 2'b00,  0,  0,  0,  0};
    vecs[1]  = '{2'b00, 2'b00, 2'b11,  0,  0, 0, 0,   0,  0, 0, 0,  2'b00, 2'b00,  0,  0,  0,  0};
    vecs[2]  = '{2'b01, 2'b00, 2'b01,  5,  3, 1, 2,  33,  1, 0,15,  2'b01, 2'b01,  2,  2,  0,  0};
    vecs[3]  = '{2'b11, 2'b00, 2'b11, 40,  1, 0, 1,  10,  4, 0, 5,  2'b10, 2'b10,  2,  2, 14,  5};
    vecs[4]  = '{2'b11, 2'b00, 2'b11,  7,  1, 0, 3,  60,  6, 1,12,  2'b01, 2'b01,  8,  3, 14,  5};
    vecs[5]  = '{2'b11, 2'b00, 2'b11, 44,  4, 0,11,  20,  5, 1, 6,  2'b10, 2'b10,  8,  3, 15,  6};
    vecs[6]  = '{2'b11, 2'b00, 2'b11,  9,  9, 0, 4,  70,  7, 0,13,  2'b01, 2'b01, 18,  4, 15,  6};
    vecs[7]  = '{2'b11, 2'b00, 2'b01, 55,  5, 0,14, 100,  1, 1, 7,  2'b10, 2'b10, 18,  4, 99,  7};
    vecs[8]  = '{2'b11, 2'b00, 2'b01,  1,  2, 0, 1,  80,  8, 0, 2,  2'b01, 2'b11,  3,  1, 99,  7};
    vecs[9]  = '{2'b11, 2'b00, 2'b01,  3,  3, 0, 8,  81,  8, 0, 3,  2'b01, 2'b11,  6,  8, 99,  7};
    vecs[10] = '{2'b11, 2'b01, 2'b10, 77,  7, 0,12,  50,  8, 1, 9,  2'b10, 2'b10,  6,  8, 42,  9};
    vecs[11] = '{2'b01, 2'b00, 2'b00,  2,  2, 1,10,  90,  9, 0, 4,  2'b01, 2'b11,  0, 10, 42,  9};

    reset = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rspvalid", {62'd0, RspValid}, 64'd0);
    chk("reset_result0", RspResult[0], 64'd0);
    chk("reset_tag1", {60'd0, RspTag[1]}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].flush, vecs[i].rdy,
            vecs[i].a0, vecs[i].b0, vecs[i].s0, vecs[i].t0,
            vecs[i].a1, vecs[i].b1, vecs[i].s1, vecs[i].t1);
      #1;
      chk($sformatf("v%0d_reqready", i), {62'd0, ReqReady}, {62'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rspvalid", i), {62'd0, RspValid}, {62'd0, vecs[i].exp_rv});
      chk($sformatf("v%0d_result0", i), RspResult[0], {56'd0, vecs[i].exp_r0});
      chk($sformatf("v%0d_tag0", i), {60'd0, RspTag[0]}, {60'd0, vecs[i].exp_t0});
      chk($sformatf("v%0d_result1", i), RspResult[1], {56'd0, vecs[i].exp_r1});
      chk($sformatf("v%0d_tag1", i), {60'd0, RspTag[1]}, {60'd0, vecs[i].exp_t1});
      @(negedge clk);
    end

    // Mid-operation reset with both slots full: clears at once, and the tie after release goes to requester 0.
    drive(2'b11, 2'b00, 2'b00, 12, 2, 0, 3, 30, 10, 1, 6);
    reset = 1'b0;
    #1;
    chk("async_reset_rspvalid", {62'd0, RspValid}, 64'd0);
    chk("async_reset_reqready", {62'd0, ReqReady}, 64'd0);
    chk("async_reset_result0", RspResult[0], 64'd0);
    @(negedge clk);
    reset = 1'b1;
    RspReady = 2'b11;
    #1;
    chk("post_reset_tie", {62'd0, ReqReady}, 64'd1);
    @(posedge clk);
    #1;
    chk("post_reset_rspvalid", {62'd0, RspValid}, 64'd1);
    chk("post_reset_result0", RspResult[0], 64'd14);
    chk("post_reset_tag0", {60'd0, RspTag[0]}, 64'd3);
    @(negedge clk);
    #1;
    chk("post_reset_alternate", {62'd0, ReqReady}, 64'd2);
    @(posedge clk);
    #1;
    chk("post_reset_result1", RspResult[1], 64'd20);
    @(negedge clk);
    Flush = 2'b11;
    #1;
    chk("flush_both_reqready", {62'd0, ReqReady}, 64'd0);
    @(posedge clk);
    #1;
    chk("flush_both_rspvalid", {62'd0, RspValid}, 64'd0);
    chk("flush_holds_result1", RspResult[1], 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
